// File: rtl/prach_mixer_if.sv
// Bundle of the prach_mixer sample, NCO, output and error-control signals.
// The DUT connects through the slave modport. The driving side connects through the master modport.
interface prach_mixer_if;
    // raw samples, same cycle as the NCO's din
    logic signed [15:0] din_i;
    logic signed [15:0] din_q;
    logic               din_dv;
    logic [7:0]         din_chn;
    logic               sync_in;
    // NCO output, e^(-j*phi) as cos/sin in fi(1,16,14)
    logic signed [15:0] nco_cos;
    logic signed [15:0] nco_sin;
    logic               nco_dv;
    logic [7:0]         nco_chn;
    // sticky alignment-error control
    logic               err_clr;
    logic               align_err;
    // mixed output in fi(1,16,15)
    logic signed [15:0] dout_i;
    logic signed [15:0] dout_q;
    logic               dout_dv;
    logic [7:0]         dout_chn;
    logic               sync_out;

    modport master (
        output din_i, din_q, din_dv, din_chn, sync_in,
        output nco_cos, nco_sin, nco_dv, nco_chn,
        output err_clr,
        input  dout_i, dout_q, dout_dv, dout_chn, sync_out, align_err
    );

    modport slave (
        input  din_i, din_q, din_dv, din_chn, sync_in,
        input  nco_cos, nco_sin, nco_dv, nco_chn,
        input  err_clr,
        output dout_i, dout_q, dout_dv, dout_chn, sync_out, align_err
    );
endinterface

// File: rtl/prach_mixer.sv
// PRACH complex down-conversion mixer.
// Raw IQ is delayed to line up with the NCO output (stage A).
// The pipeline then forms I*cos+Q*sin and Q*cos-I*sin over three registered stages:
//   M1: products
//   M2: round half-up and shift right by 14
//   M3: saturate to 16 bits; this stage is the output register.
// Control (dv, chn, sync) flows every cycle. Data stages load only with valid samples.
module prach_mixer #(
    parameter int NCO_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    prach_mixer_if.slave  bus
);

    // packed alignment word: {i[15:0], q[15:0], dv, chn[7:0], sync}
    localparam int SW = 42;
    localparam logic signed [18:0] SAT_MAX  = 19'sd32767;
    localparam logic signed [18:0] SAT_MIN  = -19'sd32768;
    localparam logic signed [32:0] RND_HALF = 33'sd8192;

    // clamp the post-shift sum into the signed 16-bit output range
    function automatic logic signed [15:0] sat16(input logic signed [18:0] x);
        logic signed [15:0] r;
        if (x > SAT_MAX) begin
            r = 16'sh7fff;
        end else if (x < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

    // alignment delay line
    logic [SW-1:0] dly_d [NCO_LATENCY];
    logic [SW-1:0] dly_q [NCO_LATENCY];

    // stage A (output of the delay line)
    logic signed [15:0] a_i_s;
    logic signed [15:0] a_q_s;
    logic               a_dv_s;
    logic [7:0]         a_chn_s;
    logic               a_sync_s;
    logic               mismatch_s;
    logic               err_d, err_q;

    // M1: products
    logic signed [31:0] m1_ic_d, m1_ic_q;
    logic signed [31:0] m1_qs_d, m1_qs_q;
    logic signed [31:0] m1_qc_d, m1_qc_q;
    logic signed [31:0] m1_is_d, m1_is_q;
    logic               m1_dv_d, m1_dv_q;
    logic [7:0]         m1_chn_d, m1_chn_q;
    logic               m1_sync_d, m1_sync_q;

    // M2: rounded, shifted sums
    logic signed [32:0] sum_i_s;
    logic signed [32:0] sum_q_s;
    logic signed [18:0] m2_i_d, m2_i_q;
    logic signed [18:0] m2_q_d, m2_q_q;
    logic               m2_dv_d, m2_dv_q;
    logic [7:0]         m2_chn_d, m2_chn_q;
    logic               m2_sync_d, m2_sync_q;

    // M3: saturated output register
    logic signed [15:0] dout_i_d, dout_i_q;
    logic signed [15:0] dout_q_d, dout_q_q;
    logic               dout_dv_d, dout_dv_q;
    logic [7:0]         dout_chn_d, dout_chn_q;
    logic               sync_out_d, sync_out_q;

    // shift the raw input word one tap down the alignment line every cycle
    always_comb begin
        dly_d[0] = {bus.din_i, bus.din_q, bus.din_dv, bus.din_chn, bus.sync_in};
        for (int k = 1; k < NCO_LATENCY; k++) begin
            dly_d[k] = dly_q[k-1];
        end
    end

    assign {a_i_s, a_q_s, a_dv_s, a_chn_s, a_sync_s} = dly_q[NCO_LATENCY-1];

    // compare the aligned tag with the NCO tag and keep the sticky error (set beats clear)
    always_comb begin
        mismatch_s = 1'b0;
        err_d      = err_q;
        if (a_dv_s != bus.nco_dv) begin
            mismatch_s = 1'b1;
        end else if (a_dv_s && (a_chn_s[2:0] != bus.nco_chn[2:0])) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
        if (mismatch_s) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // M1: four signed 16x16 products, loaded only for valid stage-A samples
    always_comb begin
        m1_dv_d   = a_dv_s;
        m1_chn_d  = a_chn_s;
        m1_sync_d = a_sync_s;
        m1_ic_d   = m1_ic_q;
        m1_qs_d   = m1_qs_q;
        m1_qc_d   = m1_qc_q;
        m1_is_d   = m1_is_q;
        if (a_dv_s) begin
            m1_ic_d = 32'(a_i_s) * 32'(bus.nco_cos);
            m1_qs_d = 32'(a_q_s) * 32'(bus.nco_sin);
            m1_qc_d = 32'(a_q_s) * 32'(bus.nco_cos);
            m1_is_d = 32'(a_i_s) * 32'(bus.nco_sin);
        end else begin
            m1_ic_d = m1_ic_q;
            m1_qs_d = m1_qs_q;
            m1_qc_d = m1_qc_q;
            m1_is_d = m1_is_q;
        end
    end

    // M2: 33-bit sums plus half an LSB, then drop 14 fractional bits (floor)
    always_comb begin
        sum_i_s   = 33'(m1_ic_q) + 33'(m1_qs_q) + RND_HALF;
        sum_q_s   = 33'(m1_qc_q) - 33'(m1_is_q) + RND_HALF;
        m2_dv_d   = m1_dv_q;
        m2_chn_d  = m1_chn_q;
        m2_sync_d = m1_sync_q;
        m2_i_d    = m2_i_q;
        m2_q_d    = m2_q_q;
        if (m1_dv_q) begin
            m2_i_d = sum_i_s[32:14];
            m2_q_d = sum_q_s[32:14];
        end else begin
            m2_i_d = m2_i_q;
            m2_q_d = m2_q_q;
        end
    end

    // M3: saturate into the output register, holding data across dv gaps
    always_comb begin
        dout_dv_d  = m2_dv_q;
        dout_chn_d = m2_chn_q;
        sync_out_d = m2_sync_q;
        dout_i_d   = dout_i_q;
        dout_q_d   = dout_q_q;
        if (m2_dv_q) begin
            dout_i_d = sat16(m2_i_q);
            dout_q_d = sat16(m2_q_q);
        end else begin
            dout_i_d = dout_i_q;
            dout_q_d = dout_q_q;
        end
    end

    // all pipeline state, with asynchronous clear of everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCO_LATENCY; k++) begin
                dly_q[k] <= '0;
            end
            err_q      <= 1'b0;
            m1_ic_q    <= '0;
            m1_qs_q    <= '0;
            m1_qc_q    <= '0;
            m1_is_q    <= '0;
            m1_dv_q    <= 1'b0;
            m1_chn_q   <= 8'd0;
            m1_sync_q  <= 1'b0;
            m2_i_q     <= '0;
            m2_q_q     <= '0;
            m2_dv_q    <= 1'b0;
            m2_chn_q   <= 8'd0;
            m2_sync_q  <= 1'b0;
            dout_i_q   <= 16'sd0;
            dout_q_q   <= 16'sd0;
            dout_dv_q  <= 1'b0;
            dout_chn_q <= 8'd0;
            sync_out_q <= 1'b0;
        end else begin
            dly_q      <= dly_d;
            err_q      <= err_d;
            m1_ic_q    <= m1_ic_d;
            m1_qs_q    <= m1_qs_d;
            m1_qc_q    <= m1_qc_d;
            m1_is_q    <= m1_is_d;
            m1_dv_q    <= m1_dv_d;
            m1_chn_q   <= m1_chn_d;
            m1_sync_q  <= m1_sync_d;
            m2_i_q     <= m2_i_d;
            m2_q_q     <= m2_q_d;
            m2_dv_q    <= m2_dv_d;
            m2_chn_q   <= m2_chn_d;
            m2_sync_q  <= m2_sync_d;
            dout_i_q   <= dout_i_d;
            dout_q_q   <= dout_q_d;
            dout_dv_q  <= dout_dv_d;
            dout_chn_q <= dout_chn_d;
            sync_out_q <= sync_out_d;
        end
    end

    assign bus.dout_i    = dout_i_q;
    assign bus.dout_q    = dout_q_q;
    assign bus.dout_dv   = dout_dv_q;
    assign bus.dout_chn  = dout_chn_q;
    assign bus.sync_out  = sync_out_q;
    assign bus.align_err = err_q;

endmodule

// File: tb/tb_prach_mixer.sv
// Self-checking bench for prach_mixer.
// The bench plays the NCO: each sample carries the cos/sin it is to be mixed with.
// That cos/sin is driven on the NCO port four cycles after the sample enters.
// Expected outputs come from integer arithmetic on the mixing equations.
module tb_prach_mixer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prach_mixer_if bus ();

    prach_mixer #(.NCO_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic signed [15:0] cs;
        logic signed [15:0] sn;
        logic               dv;
        logic [7:0]         chn;
        logic               sync;
    } rec_t;

    rec_t hist[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic signed [15:0] hold_i, hold_q, exp_i, exp_q;
    logic               exp_dv, exp_sync, exp_err;
    logic [7:0]         exp_chn;

    function automatic rec_t mk(int i, int q, bit dv, int chn, bit sync, int cs, int sn);
        rec_t r;
        r.i = 16'(i); r.q = 16'(q); r.dv = dv; r.chn = 8'(chn);
        r.sync = sync; r.cs = 16'(cs); r.sn = 16'(sn);
        return r;
    endfunction

    function automatic rec_t rnd_rec(bit dv);
        rec_t r;
        r.i = 16'($urandom); r.q = 16'($urandom);
        r.cs = 16'($urandom); r.sn = 16'($urandom);
        r.dv = dv; r.chn = 8'($urandom);
        r.sync = ($urandom_range(7) == 0);
        return r;
    endfunction

    // value/2^14 rounded half-up (floor of value/2^14 + 1/2), clamped to int16
    function automatic logic signed [15:0] ref_mix(longint acc);
        longint y, f;
        y = acc + 64'sd8192;
        if (y >= 0) f = y / 16384;
        else        f = -((-y + 16383) / 16384);
        if (f > 32767)  f = 32767;
        if (f < -32768) f = -32768;
        return 16'(f);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 7; k++) hist.push_back(mk(0, 0, 1'b0, 0, 1'b0, 0, 0));
        hold_i = 16'sd0; hold_q = 16'sd0; exp_err = 1'b0;
        exp_i = 16'sd0; exp_q = 16'sd0; exp_dv = 1'b0; exp_chn = 8'd0; exp_sync = 1'b0;
    endtask

    // drive one cycle (called at negedge), advance one clock, update expectations
    task automatic tick(input rec_t r, input bit clr, input bit bad, input logic [7:0] bad_chn);
        rec_t a, o;
        logic [7:0] nchn;
        bit mism;
        hist.push_back(r);
        a = hist[hist.size()-5];
        nchn = bad ? bad_chn : a.chn;
        bus.din_i = r.i; bus.din_q = r.q; bus.din_dv = r.dv; bus.din_chn = r.chn; bus.sync_in = r.sync;
        bus.nco_cos = a.cs; bus.nco_sin = a.sn; bus.nco_dv = a.dv; bus.nco_chn = nchn;
        bus.err_clr = clr;
        mism = a.dv && (nchn[2:0] != a.chn[2:0]);
        @(posedge clk);
        @(negedge clk);
        exp_err = mism ? 1'b1 : (clr ? 1'b0 : exp_err);
        o = hist[hist.size()-7];
        if (o.dv) begin
            hold_i = ref_mix(longint'(o.i) * o.cs + longint'(o.q) * o.sn);
            hold_q = ref_mix(longint'(o.q) * o.cs - longint'(o.i) * o.sn);
        end
        exp_i = hold_i; exp_q = hold_q;
        exp_dv = o.dv; exp_chn = o.chn; exp_sync = o.sync;
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) tick(mk(0, 0, 1'b0, 0, 1'b0, 0, 0), 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.din_i = 16'sd0; bus.din_q = 16'sd0; bus.din_dv = 1'b0; bus.din_chn = 8'd0; bus.sync_in = 1'b0;
        bus.nco_cos = 16'sd0; bus.nco_sin = 16'sd0; bus.nco_dv = 1'b0; bus.nco_chn = 8'd0; bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.dout_i, bus.dout_q, bus.dout_dv, bus.dout_chn, bus.sync_out, bus.align_err} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_state: got i=%0d q=%0d dv=%b chn=%0d sync=%b err=%b required all 0",
                     bus.dout_i, bus.dout_q, bus.dout_dv, bus.dout_chn, bus.sync_out, bus.align_err);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_unity_quarter();
        tick(mk(1000, -2000, 1'b1, 3, 1'b0, 16384, 0), 1'b0, 1'b0, 8'd0);
        tick(mk(1000, -2000, 1'b1, 6, 1'b0, 0, 16384), 1'b0, 1'b0, 8'd0);
        idle(4);
        n_cmp++;
        if (bus.dout_dv !== 1'b0) begin
            n_bad++; $display("FAIL unity_latency: dout_dv got %b required 0 one cycle early", bus.dout_dv);
        end
        idle(1);
        n_cmp++;
        if ({bus.dout_i, bus.dout_q, bus.dout_chn, bus.dout_dv} !== {16'sd1000, -16'sd2000, 8'd3, 1'b1}) begin
            n_bad++; $display("FAIL unity: got i=%0d q=%0d chn=%0d dv=%b required 1000 -2000 3 1",
                              bus.dout_i, bus.dout_q, bus.dout_chn, bus.dout_dv);
        end
        idle(1);
        n_cmp++;
        if ({bus.dout_i, bus.dout_q, bus.dout_chn, bus.dout_dv} !== {-16'sd2000, -16'sd1000, 8'd6, 1'b1}) begin
            n_bad++; $display("FAIL quarter: got i=%0d q=%0d chn=%0d dv=%b required -2000 -1000 6 1",
                              bus.dout_i, bus.dout_q, bus.dout_chn, bus.dout_dv);
        end
        idle(1);
        n_cmp++;
        if ({bus.dout_i, bus.dout_q, bus.dout_dv} !== {-16'sd2000, -16'sd1000, 1'b0}) begin
            n_bad++; $display("FAIL gap_hold: got i=%0d q=%0d dv=%b required -2000 -1000 0",
                              bus.dout_i, bus.dout_q, bus.dout_dv);
        end
    endtask

    task automatic test_saturation();
        tick(mk(32767, 32767, 1'b1, 1, 1'b0, 16384, 16384), 1'b0, 1'b0, 8'd0);
        tick(mk(-32768, -32768, 1'b1, 2, 1'b0, 16384, 16384), 1'b0, 1'b0, 8'd0);
        idle(5);
        n_cmp++;
        if ({bus.dout_i, bus.dout_q} !== {16'sd32767, 16'sd0}) begin
            n_bad++; $display("FAIL sat_pos: got i=%0d q=%0d required 32767 0", bus.dout_i, bus.dout_q);
        end
        idle(1);
        n_cmp++;
        if ({bus.dout_i, bus.dout_q} !== {-16'sd32768, 16'sd0}) begin
            n_bad++; $display("FAIL sat_neg: got i=%0d q=%0d required -32768 0", bus.dout_i, bus.dout_q);
        end
    endtask

    task automatic test_rounding();
        int ins[3];
        int outs[3];
        ins = '{1, -1, 3};
        outs = '{1, 0, 2};
        for (int k = 0; k < 3; k++) tick(mk(ins[k], 0, 1'b1, k, 1'b0, 8192, 0), 1'b0, 1'b0, 8'd0);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bus.dout_i !== 16'(outs[k])) begin
                n_bad++; $display("FAIL rounding_%0d: got dout_i=%0d required %0d", ins[k], bus.dout_i, outs[k]);
            end
            idle(1);
        end
    endtask

    task automatic test_align_err();
        tick(mk(0, 0, 1'b1, 4, 1'b0, 0, 0), 1'b0, 1'b0, 8'd0);
        idle(3);
        tick(mk(0, 0, 1'b0, 0, 1'b0, 0, 0), 1'b0, 1'b1, 8'd5);
        n_cmp++;
        if (bus.align_err !== 1'b1) begin
            n_bad++; $display("FAIL err_set: got %b required 1", bus.align_err);
        end
        idle(2);
        n_cmp++;
        if (bus.align_err !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky: got %b required 1", bus.align_err);
        end
        tick(mk(0, 0, 1'b0, 0, 1'b0, 0, 0), 1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (bus.align_err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b required 0", bus.align_err);
        end
        tick(mk(0, 0, 1'b1, 4, 1'b0, 0, 0), 1'b0, 1'b0, 8'd0);
        idle(3);
        tick(mk(0, 0, 1'b0, 0, 1'b0, 0, 0), 1'b1, 1'b1, 8'd5);
        n_cmp++;
        if (bus.align_err !== 1'b1) begin
            n_bad++; $display("FAIL err_set_wins: got %b required 1", bus.align_err);
        end
        tick(mk(0, 0, 1'b1, 4, 1'b0, 0, 0), 1'b1, 1'b0, 8'd0);
        idle(3);
        tick(mk(0, 0, 1'b0, 0, 1'b0, 0, 0), 1'b0, 1'b1, 8'hfc);
        n_cmp++;
        if (bus.align_err !== 1'b0) begin
            n_bad++; $display("FAIL err_upper_bits: got %b required 0", bus.align_err);
        end
    endtask

    task automatic test_back_to_back();
        rec_t pat[22];
        for (int j = 0; j < 22; j++) pat[j] = mk(0, 0, 1'b0, 0, 1'b0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            pat[j] = rnd_rec(1'b1);
            pat[j].chn = 8'(j);
            pat[j].sync = (j == 0);
        end
        pat[9] = rnd_rec(1'b1);
        pat[10] = rnd_rec(1'b0);
        pat[11] = rnd_rec(1'b1);
        for (int j = 0; j < 22; j++) begin
            tick(pat[j], 1'b0, 1'b0, 8'd0);
            if (j >= 6) begin
                n_cmp++;
                if ({bus.dout_dv, bus.dout_chn, bus.sync_out} !== {pat[j-6].dv, pat[j-6].chn, pat[j-6].sync}) begin
                    n_bad++; $display("FAIL b2b_ctrl[%0d]: got dv=%b chn=%0d sync=%b required dv=%b chn=%0d sync=%b",
                                      j - 6, bus.dout_dv, bus.dout_chn, bus.sync_out,
                                      pat[j-6].dv, pat[j-6].chn, pat[j-6].sync);
                end
                n_cmp++;
                if ({bus.dout_i, bus.dout_q} !== {exp_i, exp_q}) begin
                    n_bad++; $display("FAIL b2b_data[%0d]: got i=%0d q=%0d required i=%0d q=%0d",
                                      j - 6, bus.dout_i, bus.dout_q, exp_i, exp_q);
                end
            end
        end
    endtask

    task automatic test_random(int n);
        rec_t r;
        bit clr, bad;
        for (int k = 0; k < n; k++) begin
            r = rnd_rec($urandom_range(3) != 0);
            clr = ($urandom_range(9) == 0);
            bad = ($urandom_range(15) == 0);
            tick(r, clr, bad, 8'($urandom));
            n_cmp++;
            if ({bus.dout_dv, bus.dout_chn, bus.sync_out, bus.dout_i, bus.dout_q, bus.align_err} !==
                {exp_dv, exp_chn, exp_sync, exp_i, exp_q, exp_err}) begin
                n_bad++; $display("FAIL random[%0d]: got dv=%b chn=%0d sync=%b i=%0d q=%0d err=%b required dv=%b chn=%0d sync=%b i=%0d q=%0d err=%b",
                                  k, bus.dout_dv, bus.dout_chn, bus.sync_out, bus.dout_i, bus.dout_q, bus.align_err,
                                  exp_dv, exp_chn, exp_sync, exp_i, exp_q, exp_err);
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 6; k++) tick(rnd_rec(1'b1), 1'b0, 1'b0, 8'd0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dout_i, bus.dout_q, bus.dout_dv, bus.dout_chn, bus.sync_out, bus.align_err} !== 43'd0) begin
            n_bad++; $display("FAIL midstream_reset: got i=%0d q=%0d dv=%b chn=%0d sync=%b err=%b required all 0",
                              bus.dout_i, bus.dout_q, bus.dout_dv, bus.dout_chn, bus.sync_out, bus.align_err);
        end
        bus.din_dv = 1'b1; bus.din_chn = 8'd5; bus.nco_dv = 1'b1; bus.nco_chn = 8'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.dout_dv, bus.align_err} !== 2'b00) begin
                n_bad++; $display("FAIL in_reset_dv[%0d]: got dv=%b err=%b required 0 0", k, bus.dout_dv, bus.align_err);
            end
        end
        bus.din_dv = 1'b0; bus.din_chn = 8'd0; bus.nco_dv = 1'b0; bus.nco_chn = 8'd0;
        rst_n = 1'b1;
        model_reset();
        test_random(20);
    endtask

    initial begin
        test_reset();
        test_unity_quarter();
        test_saturation();
        test_rounding();
        test_align_err();
        test_back_to_back();
        test_random(400);
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
